mux_result_fifo: RTL and testbench
==================================

Name: mux_result_fifo

Overview:
Capture buffer directly downstream of the registered 2:1 mux stage. It accepts the mux output `y` on a valid/ready handshake and holds it in a small first-word-fall-through FIFO. Results drain to a monitor or consumer at that consumer's own pace. It also reports occupancy and a sticky overflow flag, so the layered bench can check for dropped mux results.

Parameters:
- DATA_W, 8, width of the mux result word; must match the mux `y` width.
- DEPTH, 8, number of entries; power of two, at least 2.
- ADDR_W, $clog2(DEPTH), localparam, entry index width; not overridable.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high; clears all control state immediately.
- in_valid  in  1  upstream result is valid (mux output qualifier).
- in_data  in  DATA_W  mux result `y`.
- in_ready  out  1  FIFO can accept a word this cycle.
- out_valid  out  1  `out_data` holds the oldest stored word.
- out_data  out  DATA_W  head-of-FIFO word.
- out_ready  in  1  consumer takes the head word this cycle.
- count  out  ADDR_W+1  number of stored entries, 0..DEPTH.
- overflow  out  1  sticky: a valid word was offered while full and dropped.
- clr_ovf  in  1  synchronous clear of `overflow`.

Behaviour:
- Reset values (asserted asynchronously):
  - wr_ptr = rd_ptr = 0, count = 0, overflow = 0.
  - out_valid = 0, in_ready = 1, out_data = 0.
  - Storage array is not reset.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_W+1 bits and wrap modulo 2*DEPTH.
  - full = (MSBs differ and low bits equal).
  - empty = (pointers equal).
- Push = in_valid & in_ready, with in_ready = !full (combinational from registered pointers).
  - On push: mem[wr_ptr[ADDR_W-1:0]] <= in_data and wr_ptr increments.
- Pop = out_valid & out_ready.
  - On pop: rd_ptr increments.
- Outputs:
  - out_valid = !empty.
  - out_data = mem[rd_ptr[ADDR_W-1:0]] when !empty, otherwise 0. This is first-word fall-through: a word pushed at edge N is visible on out_data/out_valid after edge N, so it can be popped at edge N+1.
- count = wr_ptr - rd_ptr, computed in ADDR_W+1 bits. It is +1 on push only, -1 on pop only, and unchanged on a simultaneous push and pop.
- Boundary cases:
  - Full, in_valid=1, out_ready=1: pop occurs. The push is NOT accepted, because in_ready was 0 that cycle. overflow sets. There is no pass-through.
  - Full, in_valid=1, out_ready=0: word dropped, overflow <= 1. Pointers and contents unchanged.
  - Empty, out_ready=1: no pop and no pointer change. out_data stays 0.
  - Empty, push and out_ready in the same cycle: only the push occurs. The word appears next cycle.
  - Pointer wrap: after 2*DEPTH pushes and pops, pointers return to 0. Data order is preserved across the wrap.
- overflow:
  - Sets on (in_valid & full).
  - Cleared by clr_ovf. A new set condition in the same cycle as clr_ovf wins (overflow stays 1).
- Reset mid-operation: all stored data is abandoned. count becomes 0 and out_valid becomes 0 immediately, without waiting for a clock edge. After rst deasserts, the first push behaves as if the FIFO is empty.
- No combinational path from out_ready to in_ready, nor from in_valid to out_valid.

Decomposition:
- Package mux_fifo_pkg holds:
  - MUX_DATA_W default constant (8);
  - typedef mux_word_t (logic [MUX_DATA_W-1:0]);
  - MUX_FIFO_DEPTH default constant (8).
- One sub-module, mux_fifo_mem: a DEPTH x DATA_W register array with a write port (we, waddr, wdata) and an asynchronous read port (raddr, rdata), with no reset.
- Pointer, flag and handshake logic live in mux_result_fifo.

Test Plan:
1. Reset, then idle -> count=0, out_valid=0, in_ready=1, overflow=0, out_data=0; asserting rst mid-test returns all of these immediately.
2. Push 8'h11, 8'h22, 8'h33 with out_ready=0, then hold out_ready=1 -> count 1,2,3 after each push; reads return 11, 22, 33 in order; count reaches 0 and out_valid drops after the third pop.
3. Push 8 words 8'h00..8'h07 with out_ready=0 -> in_ready=0, count=8. Offer 8'hAA -> overflow=1, count stays 8. Drain -> 00..07 in order, AA absent.
4. From count=4, hold in_valid=1 and out_ready=1 for 20 cycles with an incrementing pattern -> count stays 4, output equals input delayed by 4 words, pointers wrap with no corruption.
5. With overflow=1, pulse clr_ovf while not full -> overflow=0 next cycle. Repeat while full with in_valid=1 -> overflow remains 1.
6. Empty FIFO, in_valid=1 with in_data=8'h5C and out_ready=1 in the same cycle -> no pop that cycle; next cycle out_valid=1 and out_data=5C; popped on the following edge, count back to 0.

Source files
------------

// File: rtl/mux_fifo_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// mux_fifo_pkg : shared widths and word type for the mux result FIFO
// Rev 1.0
// ---------------------------------------------------------------
package mux_fifo_pkg;

  localparam int MUX_DATA_W     = 8;
  localparam int MUX_FIFO_DEPTH = 8;

  typedef logic [MUX_DATA_W-1:0] mux_word_t;

endpackage
`default_nettype wire

// File: rtl/mux_fifo_mem.sv
`default_nettype none
// ---------------------------------------------------------------
// mux_fifo_mem : DEPTH x DATA_W register array, one write port, async read
// Rev 1.0
// ---------------------------------------------------------------
module mux_fifo_mem
  import mux_fifo_pkg::*;
#(
  parameter int  DATA_W = MUX_DATA_W,
  parameter int  DEPTH  = MUX_FIFO_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DEPTH-1:0][DATA_W-1:0] w_words;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [DATA_W-1:0] word_q;
      logic [DATA_W-1:0] word_d;

      always_comb begin
        word_d = word_q;
        if (we && (waddr == ADDR_W'(gi))) begin
          word_d = wdata;
        end
      end

      // Storage holds no control meaning, so it is intentionally left unreset.
      always_ff @(posedge clk) begin
        word_q <= word_d;
      end

      assign w_words[gi] = word_q;
    end
  endgenerate

  assign rdata = w_words[raddr];

endmodule
`default_nettype wire

// File: rtl/mux_result_fifo.sv
`default_nettype none
// ---------------------------------------------------------------
// mux_result_fifo : FWFT capture FIFO behind the registered 2:1 mux,
//                   with occupancy and sticky overflow reporting
// Rev 1.0
// ---------------------------------------------------------------
module mux_result_fifo
  import mux_fifo_pkg::*;
#(
  parameter int  DATA_W = MUX_DATA_W,
  parameter int  DEPTH  = MUX_FIFO_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              clr_ovf
);

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic              w_full, w_empty, w_push, w_pop;
  logic [DATA_W-1:0] w_rd_word;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign w_push  = in_valid && !w_full;
  assign w_pop   = out_ready && !w_empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(1);
    end
    // A fresh drop outranks a clear in the same cycle.
    if (in_valid && w_full) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  mux_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (w_push),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (w_rd_word)
  );

  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : w_rd_word;
  assign count     = wr_ptr_q - rd_ptr_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_result_fifo.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_mux_result_fifo : directed and randomized check of mux_result_fifo
// Rev 1.0
// ---------------------------------------------------------------
module tb_mux_result_fifo;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic [3:0] count;
  logic       overflow;
  logic       clr_ovf = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  logic [7:0] q[$];
  logic       m_ovf = 1'b0;
  logic [7:0] t2v [3] = '{8'h11, 8'h22, 8'h33};

  mux_result_fifo #(.DATA_W(8), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: a plain queue of accepted words plus a sticky drop flag.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_ovf <= 1'b0;
    end else begin
      if (in_valid && (q.size() == DEPTH)) m_ovf <= 1'b1;
      else if (clr_ovf) m_ovf <= 1'b0;
      if (in_valid && (q.size() < DEPTH)) begin
        if (out_ready && (q.size() != 0)) void'(q.pop_front());
        q.push_back(in_data);
      end else if (out_ready && (q.size() != 0)) begin
        void'(q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_count",     32'(count),     32'(q.size()));
      chk("m_out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("m_in_ready",  32'(in_ready),  32'(q.size() < DEPTH));
      chk("m_overflow",  32'(overflow),  32'(m_ovf));
      chk("m_out_data",  32'(out_data),  (q.size() != 0) ? 32'(q[0]) : 32'h0);
    end
  end

  initial begin
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    step();
    chk("t1_count", 32'(count), 0);
    chk("t1_out_valid", 32'(out_valid), 0);
    chk("t1_in_ready", 32'(in_ready), 1);
    chk("t1_overflow", 32'(overflow), 0);
    chk("t1_out_data", 32'(out_data), 0);

    // Three pushes then drain
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = t2v[k];
      step();
      chk("t2_count_up", 32'(count), 32'(k + 1));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("t2_data", 32'(out_data), 32'(t2v[k]));
      step();
    end
    chk("t2_count_end", 32'(count), 0);
    chk("t2_valid_end", 32'(out_valid), 0);
    out_ready = 1'b0;

    // Fill, overflow, drain
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      step();
    end
    chk("t3_in_ready", 32'(in_ready), 0);
    chk("t3_count", 32'(count), 8);
    in_data = 8'hAA;
    step();
    in_valid = 1'b0;
    chk("t3_overflow", 32'(overflow), 1);
    chk("t3_count_ovf", 32'(count), 8);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t3_data", 32'(out_data), 32'(i));
      step();
    end
    chk("t3_count_end", 32'(count), 0);
    out_ready = 1'b0;

    // Clear while not full, then clear loses to a new drop
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("t5_clr", 32'(overflow), 0);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 8'(8'hC0 + i);
      step();
    end
    in_data = 8'hEE; clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("t5_set_wins", 32'(overflow), 1);
    chk("t5_count_full", 32'(count), 8);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t5_full_pop_count", 32'(count), 7);
    for (int i = 0; i < 7; i++) begin
      chk("t5_data", 32'(out_data), 32'(8'hC1 + i));
      step();
    end
    chk("t5_count_end", 32'(count), 0);
    out_ready = 1'b0;

    // Steady state at count 4 across pointer wrap
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h40 + i);
      step();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_data = 8'(8'h44 + k);
      chk("t4_data", 32'(out_data), 32'(8'h40 + k));
      chk("t4_count", 32'(count), 4);
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t4_tail", 32'(out_data), 32'(8'h54 + k));
      step();
    end
    out_ready = 1'b0;

    // Empty push with out_ready high
    in_valid = 1'b1; in_data = 8'h5C; out_ready = 1'b1;
    chk("t6_empty_valid", 32'(out_valid), 0);
    step();
    in_valid = 1'b0;
    chk("t6_valid", 32'(out_valid), 1);
    chk("t6_data", 32'(out_data), 32'h5C);
    chk("t6_count", 32'(count), 1);
    step();
    chk("t6_count_end", 32'(count), 0);
    out_ready = 1'b0;

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h90 + i);
      step();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t1r_count", 32'(count), 0);
    chk("t1r_out_valid", 32'(out_valid), 0);
    chk("t1r_in_ready", 32'(in_ready), 1);
    chk("t1r_overflow", 32'(overflow), 0);
    chk("t1r_out_data", 32'(out_data), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b1; in_data = 8'h99;
    step();
    in_valid = 1'b0;
    chk("t1r_push_count", 32'(count), 1);
    chk("t1r_push_data", 32'(out_data), 32'h99);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Randomized traffic with varying fill pressure
    for (int c = 0; c < 3000; c++) begin
      int ph;
      ph = c / 500;
      in_valid  = ($urandom_range(99) < ((ph % 2) != 0 ? 80 : 40));
      out_ready = ($urandom_range(99) < ((ph % 3) == 0 ? 30 : 75));
      in_data   = 8'($urandom);
      clr_ovf   = ($urandom_range(49) == 0);
      if ($urandom_range(399) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end
    in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
